// File: rtl/make_a_close_to_b_sequencer.sv
// ============================================================================
// Module   : make_a_close_to_b_sequencer
// Purpose  : Runs a table of (Ain, Bin) tests through a make_A_close_to_B core
//            via its Start/Qd/Ack handshake, reporting A, Flag and clock count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module make_a_close_to_b_sequencer #(
    parameter int WIDTH   = 12,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Wr_en,
    input  logic [AW-1:0]    Wr_addr,
    input  logic [WIDTH-1:0] Wr_Ain,
    input  logic [WIDTH-1:0] Wr_Bin,
    input  logic [AW:0]      Num_tests,
    input  logic             Go,
    input  logic             Qi,
    input  logic             Qd,
    input  logic [WIDTH-1:0] A_in,
    input  logic             Flag_in,
    output logic [WIDTH-1:0] Ain_out,
    output logic [WIDTH-1:0] Bin_out,
    output logic             Start,
    output logic             Ack,
    output logic             Res_valid,
    output logic [AW-1:0]    Res_index,
    output logic [WIDTH-1:0] Res_A,
    output logic             Res_Flag,
    output logic [CNT_W-1:0] Res_clocks,
    output logic             Busy,
    output logic             All_done,
    output logic             Err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [AW:0]      c_depth   = (AW+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW:0]        n_q, n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   ain_q, ain_d, bin_q, bin_d;
    logic               res_valid_q, res_valid_d;
    logic [AW-1:0]      res_index_q, res_index_d;
    logic [WIDTH-1:0]   res_a_q, res_a_d;
    logic               res_flag_q, res_flag_d;
    logic [CNT_W-1:0]   res_clocks_q, res_clocks_d;
    logic               all_done_q, all_done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   tbl_a [DEPTH];
    logic [WIDTH-1:0]   tbl_b [DEPTH];

    logic               w_wr_ok;
    logic               w_load_ops;
    logic [AW:0]        w_n_clamp;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_wr_ok   = Reset && Wr_en && (state_q == S_IDLE || state_q == S_FIN);
    assign w_n_clamp = (Num_tests > c_depth) ? c_depth : Num_tests;
    assign w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Operand table is deliberately left out of reset so a run can be repeated
    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            tbl_a[Wr_addr] <= Wr_Ain;
            tbl_b[Wr_addr] <= Wr_Bin;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        ain_d        = ain_q;
        bin_d        = bin_q;
        res_valid_d  = 1'b0;
        res_index_d  = res_index_q;
        res_a_d      = res_a_q;
        res_flag_d   = res_flag_q;
        res_clocks_d = res_clocks_q;
        all_done_d   = all_done_q;
        err_d        = err_q;
        w_load_ops   = 1'b0;

        case (state_q)
            S_IDLE, S_FIN: begin
                if (Go) begin
                    err_d = 1'b0;
                    idx_d = '0;
                    n_d   = w_n_clamp;
                    if (w_n_clamp == '0) begin
                        state_d    = S_FIN;
                        all_done_d = 1'b1;
                    end else begin
                        state_d    = S_SETUP;
                        all_done_d = 1'b0;
                        w_load_ops = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (Qi) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = w_cnt_inc;
                if (Qd) begin
                    res_valid_d  = 1'b1;
                    res_index_d  = idx_q;
                    res_a_d      = A_in;
                    res_flag_d   = Flag_in;
                    res_clocks_d = w_cnt_inc;
                    state_d      = S_ACK;
                end else if (w_cnt_inc >= c_timeout) begin
                    err_d      = 1'b1;
                    all_done_d = 1'b1;
                    state_d    = S_FIN;
                end
            end
            S_ACK: begin
                if (({1'b0, idx_q} + (AW+1)'(1)) == n_q) begin
                    all_done_d = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    idx_d      = idx_q + AW'(1);
                    state_d    = S_SETUP;
                    w_load_ops = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Operands are registered on entry to SETUP so they lead Start by a clock
        if (w_load_ops) begin
            ain_d = tbl_a[idx_d];
            bin_d = tbl_b[idx_d];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            ain_q        <= '0;
            bin_q        <= '0;
            res_valid_q  <= 1'b0;
            res_index_q  <= '0;
            res_a_q      <= '0;
            res_flag_q   <= 1'b0;
            res_clocks_q <= '0;
            all_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            ain_q        <= ain_d;
            bin_q        <= bin_d;
            res_valid_q  <= res_valid_d;
            res_index_q  <= res_index_d;
            res_a_q      <= res_a_d;
            res_flag_q   <= res_flag_d;
            res_clocks_q <= res_clocks_d;
            all_done_q   <= all_done_d;
            err_q        <= err_d;
        end
    end

    assign Ain_out    = ain_q;
    assign Bin_out    = bin_q;
    assign Start      = (state_q == S_START);
    assign Ack        = (state_q == S_ACK);
    assign Busy       = (state_q == S_SETUP) || (state_q == S_START) ||
                        (state_q == S_WAIT)  || (state_q == S_ACK);
    assign Res_valid  = res_valid_q;
    assign Res_index  = res_index_q;
    assign Res_A      = res_a_q;
    assign Res_Flag   = res_flag_q;
    assign Res_clocks = res_clocks_q;
    assign All_done   = all_done_q;
    assign Err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_make_a_close_to_b_sequencer.sv
// ============================================================================
// Module   : tb_make_a_close_to_b_sequencer
// Purpose  : Directed self-checking bench with a behavioural core model
//            (Qd three clocks after Start, A = Ain + 1, Flag = (Ain == Bin)).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_make_a_close_to_b_sequencer;

    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CNT_W = 16;
    localparam int TO    = 50;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Wr_en;
    logic [AW-1:0]    Wr_addr;
    logic [WIDTH-1:0] Wr_Ain, Wr_Bin;
    logic [AW:0]      Num_tests;
    logic             Go;
    logic             Qi, Qd;
    logic [WIDTH-1:0] A_in;
    logic             Flag_in;
    logic [WIDTH-1:0] Ain_out, Bin_out;
    logic             Start, Ack, Res_valid;
    logic [AW-1:0]    Res_index;
    logic [WIDTH-1:0] Res_A;
    logic             Res_Flag;
    logic [CNT_W-1:0] Res_clocks;
    logic             Busy, All_done, Err;

    always #5 Clk = ~Clk;

    make_a_close_to_b_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W), .TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Wr_en(Wr_en), .Wr_addr(Wr_addr),
        .Wr_Ain(Wr_Ain), .Wr_Bin(Wr_Bin), .Num_tests(Num_tests), .Go(Go),
        .Qi(Qi), .Qd(Qd), .A_in(A_in), .Flag_in(Flag_in),
        .Ain_out(Ain_out), .Bin_out(Bin_out), .Start(Start), .Ack(Ack),
        .Res_valid(Res_valid), .Res_index(Res_index), .Res_A(Res_A),
        .Res_Flag(Res_Flag), .Res_clocks(Res_clocks), .Busy(Busy),
        .All_done(All_done), .Err(Err)
    );

    // Behavioural core: 0 = INI, 1 = busy, 2 = DONE
    logic [1:0]       core_st;
    logic [2:0]       core_tmr;
    logic [2:0]       qi_hold;
    logic [WIDTH-1:0] core_a, core_b;
    int               core_acks;
    logic             core_en;
    logic             never_qd;
    int               hold_after;

    assign Qi      = (core_st == 2'd0) && (qi_hold == 3'd0);
    assign Qd      = (core_st == 2'd2);
    assign A_in    = core_a + WIDTH'(1);
    assign Flag_in = (core_a == core_b);

    always @(posedge Clk) begin
        if (!Reset || !core_en) begin
            core_st   <= 2'd0;
            core_tmr  <= 3'd0;
            qi_hold   <= 3'd0;
            core_a    <= '0;
            core_b    <= '0;
            core_acks <= 0;
        end else begin
            case (core_st)
                2'd0: begin
                    if (qi_hold != 3'd0) begin
                        qi_hold <= qi_hold - 3'd1;
                    end else if (Start) begin
                        core_a   <= Ain_out;
                        core_b   <= Bin_out;
                        core_tmr <= 3'd1;
                        core_st  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (!never_qd) begin
                        if (core_tmr == 3'd2) core_st <= 2'd2;
                        else                  core_tmr <= core_tmr + 3'd1;
                    end
                end
                default: begin
                    if (Ack) begin
                        core_st   <= 2'd0;
                        core_acks <= core_acks + 1;
                        if (core_acks + 1 == hold_after) qi_hold <= 3'd4;
                    end
                end
            endcase
        end
    end

    // Event monitor, sampled on the falling edge
    int   cyc = 0, n_start = 0, n_ack = 0, n_rv = 0, dbl = 0, last_ack_cyc = 0;
    logic prev_s = 1'b0, prev_a = 1'b0;
    int   start_cyc [64];
    int   res_i [64], res_a [64], res_f [64], res_c [64];

    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (Start && n_start < 64) begin
            start_cyc[n_start] = cyc;
            n_start = n_start + 1;
        end
        if (Ack) begin
            n_ack = n_ack + 1;
            last_ack_cyc = cyc;
        end
        if (Res_valid && n_rv < 64) begin
            res_i[n_rv] = int'(Res_index);
            res_a[n_rv] = int'(Res_A);
            res_f[n_rv] = int'(Res_Flag);
            res_c[n_rv] = int'(Res_clocks);
            n_rv = n_rv + 1;
        end
        if ((Start && prev_s) || (Ack && prev_a)) dbl = dbl + 1;
        prev_s = Start;
        prev_a = Ack;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic go_run(input int n);
        Num_tests = (AW+1)'(n);
        Go = 1'b1;
        step();
        Go = 1'b0;
    endtask

    task automatic write_entry(input int addr, input int a, input int b);
        Wr_en   = 1'b1;
        Wr_addr = AW'(addr);
        Wr_Ain  = WIDTH'(a);
        Wr_Bin  = WIDTH'(b);
        step();
        Wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int dcyc);
        int k = 0;
        while (!All_done && k < max_cyc) begin
            step();
            k++;
        end
        chk("done_within_bound", {31'd0, All_done}, 32'd1);
        dcyc = cyc;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},   {31'd0, Busy}, 0);
        chk({tag, "_start"},  {31'd0, Start}, 0);
        chk({tag, "_ack"},    {31'd0, Ack}, 0);
        chk({tag, "_rvalid"}, {31'd0, Res_valid}, 0);
        chk({tag, "_done"},   {31'd0, All_done}, 0);
        chk({tag, "_err"},    {31'd0, Err}, 0);
        chk({tag, "_res"},    {Res_Flag, Res_index, Res_A, Res_clocks}, 0);
        chk({tag, "_ops"},    {8'd0, Ain_out, Bin_out}, 0);
    endtask

    int tbl_a [5] = '{138, 112, 132, 311, 312};
    int exp_a [5] = '{139, 113, 133, 312, 313};
    int exp_f [5] = '{0, 0, 0, 0, 1};

    initial begin
        int bs, ba, br, dc, k;
        Reset = 1'b0; Go = 1'b0; Wr_en = 1'b0; Wr_addr = '0; Wr_Ain = '0; Wr_Bin = '0;
        Num_tests = '0; core_en = 1'b1; never_qd = 1'b0; hold_after = -1;

        // Reset and empty run
        step(2);
        chk_outputs_zero("reset");
        Reset = 1'b1;
        step();
        chk("post_reset_done", {31'd0, All_done}, 0);
        bs = n_start;
        go_run(0);
        chk("n0_all_done", {31'd0, All_done}, 1);
        chk("n0_busy", {31'd0, Busy}, 0);
        step(3);
        chk("n0_no_start", n_start - bs, 0);

        for (int i = 0; i < 5; i++) write_entry(i, tbl_a[i], 312);

        // Full five-test run
        bs = n_start; ba = n_ack; br = n_rv;
        go_run(5);
        chk("run5_busy", {31'd0, Busy}, 1);
        chk("run5_done_clr", {31'd0, All_done}, 0);
        wait_done(200, dc);
        chk("run5_starts", n_start - bs, 5);
        chk("run5_acks", n_ack - ba, 5);
        chk("run5_rvalid", n_rv - br, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("run5_idx%0d", i), res_i[br+i], i);
            chk($sformatf("run5_a%0d", i), res_a[br+i], exp_a[i]);
            chk($sformatf("run5_flag%0d", i), res_f[br+i], exp_f[i]);
            chk($sformatf("run5_clk%0d", i), res_c[br+i], 3);
        end
        for (int i = 1; i < 5; i++)
            chk($sformatf("run5_spacing%0d", i), start_cyc[bs+i] - start_cyc[bs+i-1], 6);
        chk("run5_done_after_ack", dc - last_ack_cyc, 1);
        chk("run5_err", {31'd0, Err}, 0);
        chk("run5_hold_a", {20'd0, Res_A}, 313);
        chk("run5_hold_idx", {29'd0, Res_index}, 4);

        // Qi held low before test 1, write and Go while busy
        hold_after = core_acks + 1;
        bs = n_start; br = n_rv;
        go_run(3);
        write_entry(1, 700, 5);
        Num_tests = 4'd1;
        Go = 1'b1;
        step();
        Go = 1'b0;
        wait_done(200, dc);
        chk("busy_run_rvalid", n_rv - br, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_run_idx%0d", i), res_i[br+i], i);
            chk($sformatf("busy_run_a%0d", i), res_a[br+i], exp_a[i]);
        end
        chk("qi_delay_spacing", start_cyc[bs+1] - start_cyc[bs], 10);
        chk("qi_normal_spacing", start_cyc[bs+2] - start_cyc[bs+1], 6);

        // Timeout
        never_qd = 1'b1;
        bs = n_start; ba = n_ack; br = n_rv;
        go_run(2);
        wait_done(200, dc);
        chk("to_err", {31'd0, Err}, 1);
        chk("to_busy", {31'd0, Busy}, 0);
        chk("to_starts", n_start - bs, 1);
        chk("to_acks", n_ack - ba, 0);
        chk("to_rvalid", n_rv - br, 0);
        chk("to_wait_len", dc - start_cyc[bs], TO + 1);
        core_en = 1'b0;
        step();
        core_en = 1'b1;
        never_qd = 1'b0;
        go_run(0);
        chk("to_err_cleared", {31'd0, Err}, 0);
        chk("to_done_again", {31'd0, All_done}, 1);

        // Reset in the WAIT of test 2
        bs = n_start;
        go_run(5);
        k = 0;
        while (n_start - bs < 3 && k < 100) begin
            step();
            k++;
        end
        chk("mid_reach_test2", n_start - bs, 3);
        step();
        chk("mid_in_wait", {30'd0, Busy, Start}, 2);
        Reset = 1'b0;
        step();
        chk_outputs_zero("mid_reset");
        Reset = 1'b1;
        step();
        br = n_rv;
        go_run(5);
        wait_done(200, dc);
        chk("rerun_rvalid", n_rv - br, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rerun_idx%0d", i), res_i[br+i], i);
            chk($sformatf("rerun_a%0d", i), res_a[br+i], exp_a[i]);
        end
        chk("no_double_pulses", dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/make_a_close_to_b_sequencer.md
Name: make_A_close_to_B_sequencer

Overview:
Synthesizable higher-order controller that drives a make_A_close_to_B core through its Start / Qd / Ack handshake. It plays the initiator role. It holds a small operand table of (Ain, Bin) pairs and runs a programmed number of tests back to back. For each test it reports the core's A result, its Flag and the number of clocks the test took. It sits between a host/register interface and one make_A_close_to_B instance.

Parameters:
WIDTH, 12, operand/result width (matches core A/B width)
DEPTH, 8, operand table entries (power of 2)
AW, 3, table address width, log2(DEPTH)
CNT_W, 16, clock-count width
TIMEOUT, 1000, max WAIT cycles before abort

Ports:
Clk  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-low; sampled on rising edge of Clk
Wr_en  in  1  write operand table entry
Wr_addr  in  AW  table write address
Wr_Ain  in  WIDTH  Ain value to store
Wr_Bin  in  WIDTH  Bin value to store
Num_tests  in  AW+1  number of table entries to run (0..DEPTH)
Go  in  1  start a run
Qi  in  1  core INI state
Qd  in  1  core DONE state
A_in  in  WIDTH  core A result
Flag_in  in  1  core Flag
Ain_out  out  WIDTH  operand A to core
Bin_out  out  WIDTH  operand B to core
Start  out  1  core Start, one-clock pulse
Ack  out  1  core Ack, one-clock pulse
Res_valid  out  1  one-clock pulse, result fields valid
Res_index  out  AW  table index of result
Res_A  out  WIDTH  captured A_in
Res_Flag  out  1  captured Flag_in
Res_clocks  out  CNT_W  clocks taken by this test
Busy  out  1  run in progress
All_done  out  1  run finished (level)
Err  out  1  run aborted on timeout (level)

Behaviour:
- Reset==0 at a rising edge: state IDLE, idx=0; every output 0 from that edge on, including Res_*, All_done and Err. Operand table is not cleared. Reset has priority in every state, including mid-WAIT.
- States: IDLE, SETUP, START, WAIT, ACK, FIN. Busy=1 in SETUP/START/WAIT/ACK only.
- Table writes are accepted only in IDLE or FIN. Wr_en while Busy is ignored.
- IDLE/FIN, Go=1:
  - Clear All_done and Err; idx=0; latch N=min(Num_tests, DEPTH).
  - N==0: go to FIN and set All_done next clock; no Start is issued.
  - N>0: go to SETUP.
- SETUP:
  - Ain_out/Bin_out = table[idx], held stable until the next SETUP.
  - Stay while Qi==0; this covers a core still in DONE or ADJ.
  - Leave on the first clock with Qi==1 -> START. Operands are therefore stable at least 1 clock before Start.
- START: Start=1 for exactly this one cycle; cnt=0 -> WAIT.
- WAIT:
  - Start=0; cnt increments by 1 each clock, saturating at all-ones.
  - On the clock Qd==1: Res_A=A_in, Res_Flag=Flag_in, Res_index=idx, Res_clocks=cnt+1 (minimum 1); Res_valid=1 for the following cycle only -> ACK.
  - Qd is not sampled in START, so a Qd pulse coincident with Start is not accepted.
- ACK: Ack=1 for exactly this one cycle.
  - idx==N-1: -> FIN, All_done=1.
  - Otherwise: idx+1 -> SETUP.
- Timeout: if cnt+1 reaches TIMEOUT in WAIT without Qd:
  - Err=1 and All_done=1 -> FIN.
  - No Res_valid and no Ack for that test.
- FIN: All_done and Err hold until the next Go or reset. Ain_out/Bin_out hold their last values.
- Go is ignored while Busy.
- Result fields hold their values between Res_valid pulses.

Test Plan:
- Reset low 2 clocks, then high -> all outputs 0; Go=1 with N=0 -> All_done=1 one clock later; Start never asserted.
- Load (138,312),(112,312),(132,312),(311,312),(312,312); N=5; Go, with a real make_A_close_to_B core -> 5 Res_valid pulses, Res_index 0..4. Res_A and Res_Flag match the core per test. Start and Ack each high exactly 1 cycle per test; All_done after the 5th Ack.
- Behavioural core asserting Qd 3 clocks after Start and returning to INI on Ack -> Res_clocks=3 every test; Start-to-Start spacing is constant. Qi held low 4 extra clocks before a test -> Start delayed exactly 4 clocks.
- Core model never asserts Qd, TIMEOUT=50 -> Err=1 and All_done=1 after 50 WAIT cycles; no Res_valid or Ack; next Go clears Err.
- Reset driven low mid-WAIT of test 2 -> all outputs 0 at that edge; after release, Go with N=5 reruns from index 0 with the table intact.
- Wr_en to address 1 while Busy -> table unchanged, test 1 uses the old values; Go pulsed while Busy -> no effect on the run.
